// File: rtl/branch_redirect_controller.sv
// Sequences EX-stage branch/jump redirects into fetch: captures the target,
// holds pc_sel through fetch stalls, then squashes wrong-path IF/ID, ID/EX.
//
// Ports:
//   CLK, RESET        clock, synchronous active-high reset
//   ex_valid          EX holds a real instruction
//   take_in           branch taken / jump
//   target_in         redirect target
//   fetch_stall       PC update blocked this cycle
//   pc_sel            PC loads pc_target instead of PC+4
//   pc_target         registered redirect target
//   flush_if_id       squash IF/ID
//   flush_id_ex       squash ID/EX
//   redirect_busy     controller not idle
//   misalign_err      one-cycle pulse on an unaligned taken target
//   redirect_count    completed redirects, saturating
module branch_redirect_controller #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  ex_valid,
    input  logic                  take_in,
    input  logic [ADDR_WIDTH-1:0] target_in,
    input  logic                  fetch_stall,
    output logic                  pc_sel,
    output logic [ADDR_WIDTH-1:0] pc_target,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic                  redirect_busy,
    output logic                  misalign_err,
    output logic [CNT_WIDTH-1:0]  redirect_count
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] REDIRECT = 2'd1;
    localparam logic [1:0] FLUSH    = 2'd2;

    // Cycles still to flush after the completing REDIRECT cycle.
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    logic [1:0] state;
    logic [3:0] flush_cnt;
    logic       accept;
    logic       aligned;
    logic       cnt_full;

    assign accept   = ex_valid & take_in;
    assign aligned  = (target_in[1:0] == 2'b00);
    assign cnt_full = &redirect_count;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state          <= IDLE;
            pc_target      <= '0;
            flush_cnt      <= '0;
            misalign_err   <= 1'b0;
            redirect_count <= '0;
        end else begin
            misalign_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (aligned) begin
                            pc_target <= target_in;
                            state     <= REDIRECT;
                        end else begin
                            misalign_err <= 1'b1;
                        end
                    end
                end
                REDIRECT: begin
                    // The redirect only lands once fetch can take the new PC.
                    if (!fetch_stall) begin
                        if (!cnt_full) begin
                            redirect_count <= redirect_count + 1'b1;
                        end
                        flush_cnt <= FLUSH_LOAD;
                        state     <= (FLUSH_CYCLES == 1) ? IDLE : FLUSH;
                    end
                end
                FLUSH: begin
                    flush_cnt <= flush_cnt - 1'b1;
                    if (flush_cnt == 4'd1) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Moore decode of registered state only.
    always_comb begin
        pc_sel        = 1'b0;
        flush_if_id   = 1'b0;
        flush_id_ex   = 1'b0;
        redirect_busy = 1'b0;
        unique case (1'b1)
            (state == REDIRECT): begin
                pc_sel        = 1'b1;
                flush_if_id   = 1'b1;
                flush_id_ex   = 1'b1;
                redirect_busy = 1'b1;
            end
            (state == FLUSH): begin
                flush_if_id   = 1'b1;
                flush_id_ex   = 1'b1;
                redirect_busy = 1'b1;
            end
            default: begin
                pc_sel = 1'b0;
            end
        endcase
    end

endmodule
